decoder_nto2n_seq: RTL and testbench

Parametrised, registered N-to-2^N one-hot decoder with a valid/ready command interface and a programmable pulse width. In single mode it drives one selected output line for a set number of cycles. In scan mode it walks every output line in turn, starting at the requested index and wrapping around. It sits between a command source (CPU register, test sequencer) and strobe/enable fan-out logic, and generalises the combinational 2-to-4 decoder.

---
 rtl/decoder_nto2n_seq.sv | 158 +++++++++++++++
 tb/tb_decoder_nto2n_seq.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/decoder_nto2n_seq.sv
`default_nettype none
// ============================================================================
//  Module   : decoder_nto2n_seq
//  Purpose  : Registered N-to-2^N one-hot decoder with a valid/ready command
//             interface and a programmable pulse width. Single mode holds the
//             selected line for PULSE_LEN cycles; scan mode walks all 2^SEL_W
//             lines starting at the requested index, wrapping around, each
//             held PULSE_LEN cycles.
//  Ports    : clk       - clock, rising edge
//             rst       - synchronous active-high reset
//             in_valid  - command present
//             in_ready  - block can accept a command (combinational, IDLE)
//             sel       - start index, captured on accept
//             mode      - 0 = single, 1 = scan, captured on accept
//             y         - registered one-hot output, 2**SEL_W bits
//             busy      - command executing
//             done      - one-cycle pulse on command completion
//  Config   : DECODER_ACTIVE_LOW_EN - when defined, y is active-low
//             (idle/reset drives all ones, the active line is 0).
//  Revision : 1.0 - initial release
// ============================================================================
module decoder_nto2n_seq #(
    parameter int SEL_W     = 2,
    parameter int PULSE_LEN = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SEL_W-1:0]      sel,
    input  logic                  mode,
    output logic [2**SEL_W-1:0]   y,
    output logic                  busy,
    output logic                  done
);

    localparam int c_OUT_W = 2**SEL_W;
    // One extra value of headroom so PULSE_LEN itself is representable.
    localparam int c_CYC_W = $clog2(PULSE_LEN + 1);
    localparam logic [c_CYC_W-1:0] c_LAST_CYC  = c_CYC_W'(PULSE_LEN - 1);
    localparam logic [SEL_W:0]     c_LAST_STEP = (SEL_W + 1)'(c_OUT_W - 1);

`ifdef DECODER_ACTIVE_LOW_EN
    localparam logic c_ACTIVE_LOW = 1'b1;
`else
    localparam logic c_ACTIVE_LOW = 1'b0;
`endif

    // Inactive output pattern; XOR-ing a one-hot vector with it yields the
    // correctly polarised active pattern in either configuration.
    localparam logic [c_OUT_W-1:0] c_Y_IDLE = {c_OUT_W{c_ACTIVE_LOW}};

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t               r_state;
    logic [SEL_W-1:0]     r_idx;
    logic [c_CYC_W-1:0]   r_cyc;
    logic [SEL_W:0]       r_step;
    logic                 r_mode;
    logic [c_OUT_W-1:0]   r_y;
    logic                 r_done;

    state_t               w_state_nxt;
    logic [SEL_W-1:0]     w_idx_nxt;
    logic [c_CYC_W-1:0]   w_cyc_nxt;
    logic [SEL_W:0]       w_step_nxt;
    logic                 w_mode_nxt;
    logic                 w_done_nxt;
    logic [c_OUT_W-1:0]   w_onehot;
    logic [c_OUT_W-1:0]   w_y_nxt;
    logic                 w_accept;

    assign in_ready = (r_state == S_IDLE) && !rst;
    assign w_accept = in_valid && in_ready;

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cyc_nxt   = r_cyc;
        w_step_nxt  = r_step;
        w_mode_nxt  = r_mode;
        w_done_nxt  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_HOLD;
                    w_idx_nxt   = sel;
                    w_cyc_nxt   = '0;
                    w_step_nxt  = '0;
                    w_mode_nxt  = mode;
                end
            end

            S_HOLD: begin
                if (r_cyc == c_LAST_CYC) begin
                    if (!r_mode || (r_step == c_LAST_STEP)) begin
                        w_state_nxt = S_IDLE;
                        w_cyc_nxt   = '0;
                        w_step_nxt  = '0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        // idx is exactly SEL_W bits, so the +1 wraps by itself.
                        w_idx_nxt  = r_idx + 1'b1;
                        w_step_nxt = r_step + 1'b1;
                        w_cyc_nxt  = '0;
                    end
                end else begin
                    w_cyc_nxt = r_cyc + 1'b1;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // The output register is loaded from the next index, so y changes on
    // the same edge as the index and can never be momentarily multi-hot.
    assign w_onehot = c_OUT_W'(1) << w_idx_nxt;
    assign w_y_nxt  = (w_state_nxt == S_HOLD) ? (w_onehot ^ c_Y_IDLE) : c_Y_IDLE;

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_cyc   <= '0;
            r_step  <= '0;
            r_mode  <= 1'b0;
            r_y     <= c_Y_IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_cyc   <= w_cyc_nxt;
            r_step  <= w_step_nxt;
            r_mode  <= w_mode_nxt;
            r_y     <= w_y_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign y    = r_y;
    assign busy = (r_state == S_HOLD);
    assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_decoder_nto2n_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_decoder_nto2n_seq
//  Purpose  : Self-checking bench for decoder_nto2n_seq. DUT A uses
//             SEL_W=2/PULSE_LEN=3 and is driven from a cycle-by-cycle vector
//             table (single, scan with wrap, backpressure); hand-written
//             sequences cover reset mid-scan on A and a PULSE_LEN=1 scan on
//             DUT B (SEL_W=3). Expectations are written active-high and the
//             output is re-polarised when DECODER_ACTIVE_LOW_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_decoder_nto2n_seq;

`ifdef DECODER_ACTIVE_LOW_EN
    localparam logic c_ACT_LOW = 1'b1;
`else
    localparam logic c_ACT_LOW = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    always #5 clk = ~clk;

    logic       a_valid, a_ready, a_mode, a_busy, a_done;
    logic [1:0] a_sel;
    logic [3:0] a_y, a_yh;
    logic       b_valid, b_ready, b_mode, b_busy, b_done;
    logic [2:0] b_sel;
    logic [7:0] b_y, b_yh;

    assign a_yh = c_ACT_LOW ? ~a_y : a_y;
    assign b_yh = c_ACT_LOW ? ~b_y : b_y;

    decoder_nto2n_seq #(.SEL_W(2), .PULSE_LEN(3)) u_dut_a (
        .clk(clk), .rst(rst), .in_valid(a_valid), .in_ready(a_ready),
        .sel(a_sel), .mode(a_mode), .y(a_y), .busy(a_busy), .done(a_done)
    );

    decoder_nto2n_seq #(.SEL_W(3), .PULSE_LEN(1)) u_dut_b (
        .clk(clk), .rst(rst), .in_valid(b_valid), .in_ready(b_ready),
        .sel(b_sel), .mode(b_mode), .y(b_y), .busy(b_busy), .done(b_done)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic       valid;
        logic [1:0] sel;
        logic       mode;
        logic [3:0] y;      // active-high expectation after the edge
        logic       busy;
        logic       done;
        logic       ready;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic v, input logic [1:0] s, input logic m,
                       input logic [3:0] ey, input logic eb, input logic ed, input logic er);
        vec_t t;
        t.valid = v; t.sel = s; t.mode = m;
        t.y = ey; t.busy = eb; t.done = ed; t.ready = er;
        tbl.push_back(t);
    endtask

    initial begin
        // ---- single mode, sel=2 ----
        add(1, 2, 0, 4'b0100, 1, 0, 0);
        add(0, 0, 0, 4'b0100, 1, 0, 0);
        add(0, 0, 0, 4'b0100, 1, 0, 0);
        add(0, 0, 0, 4'b0000, 0, 1, 1);
        add(0, 0, 0, 4'b0000, 0, 0, 1);
        // ---- scan mode, sel=3, wraps 3 -> 0; input changes ignored ----
        add(1, 3, 1, 4'b1000, 1, 0, 0);
        add(0, 0, 0, 4'b1000, 1, 0, 0);
        add(0, 1, 0, 4'b1000, 1, 0, 0);
        add(0, 0, 0, 4'b0001, 1, 0, 0);
        add(0, 0, 0, 4'b0001, 1, 0, 0);
        add(0, 0, 0, 4'b0001, 1, 0, 0);
        add(0, 0, 0, 4'b0010, 1, 0, 0);
        add(0, 0, 0, 4'b0010, 1, 0, 0);
        add(0, 0, 0, 4'b0010, 1, 0, 0);
        add(0, 0, 0, 4'b0100, 1, 0, 0);
        add(0, 0, 0, 4'b0100, 1, 0, 0);
        add(0, 0, 0, 4'b0100, 1, 0, 0);
        add(0, 0, 0, 4'b0000, 0, 1, 1);
        add(0, 0, 0, 4'b0000, 0, 0, 1);
        // ---- backpressure: sel=1 held during a single sel=2 command ----
        add(1, 2, 0, 4'b0100, 1, 0, 0);
        add(1, 1, 0, 4'b0100, 1, 0, 0);
        add(1, 1, 0, 4'b0100, 1, 0, 0);
        add(1, 1, 0, 4'b0000, 0, 1, 1);
        add(1, 1, 0, 4'b0010, 1, 0, 0);
        add(0, 0, 0, 4'b0010, 1, 0, 0);
        add(0, 0, 0, 4'b0010, 1, 0, 0);
        add(0, 0, 0, 4'b0000, 0, 1, 1);
        add(0, 0, 0, 4'b0000, 0, 0, 1);

        rst = 1'b1;
        a_valid = 0; a_sel = 0; a_mode = 0;
        b_valid = 0; b_sel = 0; b_mode = 0;

        // ---- reset state ----
        repeat (2) @(posedge clk);
        #1;
        chk("rst_a_y_raw", a_y, c_ACT_LOW ? 32'hF : 32'h0);
        chk("rst_a_busy", a_busy, 0);
        chk("rst_a_done", a_done, 0);
        chk("rst_a_ready", a_ready, 0);
        chk("rst_b_y_raw", b_y, c_ACT_LOW ? 32'hFF : 32'h0);
        chk("rst_b_busy", b_busy, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rel_a_ready", a_ready, 1);
        chk("rel_b_ready", b_ready, 1);

        // ---- table-driven sequences on DUT A ----
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            a_valid = tbl[i].valid;
            a_sel   = tbl[i].sel;
            a_mode  = tbl[i].mode;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_y", i), a_yh, tbl[i].y);
            chk($sformatf("vec%0d_busy", i), a_busy, tbl[i].busy);
            chk($sformatf("vec%0d_done", i), a_done, tbl[i].done);
            chk($sformatf("vec%0d_ready", i), a_ready, tbl[i].ready);
            chk($sformatf("vec%0d_onehot", i), $countones(a_yh), a_busy ? 1 : 0);
        end

        // ---- reset 5 cycles into a scan ----
        @(negedge clk);
        a_valid = 1; a_sel = 0; a_mode = 1;
        @(posedge clk);
        @(negedge clk);
        a_valid = 0;
        repeat (4) @(posedge clk);
        #1;
        chk("abort_pre_busy", a_busy, 1);
        chk("abort_pre_y", a_yh, 4'b0010);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_y", a_yh, 0);
        chk("abort_busy", a_busy, 0);
        chk("abort_done", a_done, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_ready", a_ready, 1);
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("abort_nodone%0d", i), a_done, 0);
            chk($sformatf("abort_idle_y%0d", i), a_yh, 0);
        end

        // ---- DUT B: SEL_W=3, PULSE_LEN=1 scan from 0 ----
        @(negedge clk);
        b_valid = 1; b_sel = 0; b_mode = 1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            b_valid = 0;
            b_sel   = 3'd5;
            chk($sformatf("b_scan_y%0d", i), b_yh, 32'(1) << i);
            chk($sformatf("b_scan_onehot%0d", i), $countones(b_yh), 1);
            chk($sformatf("b_scan_done%0d", i), b_done, 0);
        end
        @(posedge clk);
        #1;
        chk("b_end_y", b_yh, 0);
        chk("b_end_done", b_done, 1);
        chk("b_end_busy", b_busy, 0);
        @(posedge clk);
        #1;
        chk("b_done_pulse", b_done, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time bound so the bench cannot hang.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, expected finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
